assert_verdict_tracker: RTL and testbench
=========================================

Name: assert_verdict_tracker

Overview:
- Downstream consumer of the first-match sequence checker.
- Observes the same attempt-start pulse (en) that launches the checker, then that checker's match/fail pulses.
- Pairs each attempt with its verdict, measures verdict latency, and counts passes, fails and attempts.
- Flags protocol anomalies: timeout, overlapping attempts, simultaneous match/fail, spurious verdicts. Results feed the assertion status/report logic.

Parameters:
- CNT_W, 16, width of pass/fail/attempt counters (saturating)
- LAT_W, 4, width of latency counter and latency outputs
- TIMEOUT, 8, max cycles from attempt start to verdict; must be < 2**LAT_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  attempt start, same signal driven into the checker
- match  in  1  checker pass pulse
- fail  in  1  checker fail pulse
- clr  in  1  synchronous clear of counters and sticky flags
- pending  out  1  attempt in flight (FSM in WAIT)
- verdict_valid  out  1  one-cycle pulse: verdict recorded
- verdict  out  1  1=pass, 0=fail/timeout; valid with verdict_valid
- verdict_lat  out  LAT_W  latency of recorded verdict; valid with verdict_valid
- pass_cnt  out  CNT_W  passes
- fail_cnt  out  CNT_W  fails, including timeouts
- attempt_cnt  out  CNT_W  accepted attempts
- err_pulse  out  1  one-cycle pulse on any anomaly
- err_code  out  4  sticky bits: [0] timeout, [1] overlap, [2] both, [3] spurious

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is synchronous and active-low. While rst_n=0 at a clk edge: all outputs and counters are 0, FSM=IDLE, lat_cnt=0. Reset mid-attempt discards the attempt with no verdict and no error.
- All outputs are registered and update on the edge that samples the causing inputs.
- FSM IDLE: en=1 -> WAIT, lat_cnt<=1, attempt_cnt+1. match or fail =1 -> spurious: err_code[3], err_pulse; en is still honoured in the same cycle.
- FSM WAIT: pending=1.
  - fail=1 -> verdict_valid=1, verdict=0, verdict_lat=lat_cnt, fail_cnt+1.
  - else match=1 -> verdict_valid=1, verdict=1, verdict_lat=lat_cnt, pass_cnt+1.
  - match&fail together -> recorded as fail (fail has priority); also err_code[2], err_pulse.
  - No verdict and lat_cnt==TIMEOUT -> timeout: verdict_valid=1, verdict=0, verdict_lat=TIMEOUT, fail_cnt+1, err_code[0], err_pulse.
  - No verdict and lat_cnt<TIMEOUT -> lat_cnt+1.
- Leaving WAIT (verdict or timeout): en=1 in the same cycle -> back-to-back start. Stay WAIT, lat_cnt<=1, attempt_cnt+1, no error. Otherwise -> IDLE.
- en=1 in WAIT with no verdict/timeout that cycle -> overlap: err_code[1], err_pulse. The attempt is not counted and lat_cnt is unaffected.
- Counters saturate at all-ones and do not wrap.
- clr=1: pass/fail/attempt counters and err_code <=0. clr wins over a same-cycle increment or error set. FSM, lat_cnt and the verdict outputs are unaffected; err_pulse still fires.
- verdict_valid and err_pulse are 0 in every cycle without an event.

Optional Feature:
- ASSERT_VERDICT_LAT_STATS_EN defined: adds outputs lat_min and lat_max (LAT_W each).
  - Updated on each pass verdict only; fails and timeouts are excluded.
  - Reset/clr values: lat_min=all-ones, lat_max=0.
- Undefined: ports and registers are absent. All other behaviour is identical.

Decomposition:
- Shared package assert_pkg:
  - FSM state enum (IDLE, WAIT)
  - err_code bit-index localparams (ERR_TIMEOUT=0, ERR_OVERLAP=1, ERR_BOTH=2, ERR_SPURIOUS=3)
  - defaults for CNT_W and LAT_W
- One sub-module: sat_counter (parameterised width; inputs inc and clr; clr priority; saturating). Instantiated three times.

Test Plan:
- en at cycle 0, match at cycle 3 -> cycle 3: verdict_valid=1, verdict=1, verdict_lat=3; pass_cnt=1, attempt_cnt=1; pending=0 from cycle 4.
- en at cycle 0, fail at cycle 6 -> verdict=0, verdict_lat=6, fail_cnt=1, err_code=0.
- en at cycle 0, no match/fail -> cycle 8: timeout verdict, verdict_lat=8, fail_cnt=1, err_code=4'b0001.
- en at 0, en again at 2, match at 4 -> err_code[1] set at 2; attempt_cnt=1; pass with verdict_lat=4. Then match+fail together inside a new attempt -> fail_cnt+1, err_code[2] set.
- match in IDLE -> err_code[3] set, no count change. Then clr -> counters 0, err_code 0. Then rst_n=0 mid-WAIT -> pending=0 and no verdict pulse.
- Force pass_cnt to 16'hFFFF via a long pass stream -> stays 16'hFFFF. With ASSERT_VERDICT_LAT_STATS_EN defined, latencies 2, 5, 3 -> lat_min=2, lat_max=5.

Source files
------------

// File: rtl/assert_pkg.sv
// Shared types and constants for the assertion verdict tracker.
package assert_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int LAT_W_DEF = 4;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_OVERLAP  = 1;
  localparam int ERR_BOTH     = 2;
  localparam int ERR_SPURIOUS = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/assert_verdict_tracker.sv
// Pairs checker attempts with their match/fail verdicts, measures latency and flags anomalies.
// Optional macro ASSERT_VERDICT_LAT_STATS_EN adds lat_min/lat_max tracking of pass latencies.
//
// state | meaning
// IDLE  | no attempt in flight
// WAIT  | attempt started, waiting for match/fail or timeout
module assert_verdict_tracker
  import assert_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LAT_W   = LAT_W_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             match,
  input  logic             fail,
  input  logic             clr,
  output logic             pending,
  output logic             verdict_valid,
  output logic             verdict,
  output logic [LAT_W-1:0] verdict_lat,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] attempt_cnt,
  output logic             err_pulse,
  output logic [3:0]       err_code
`ifdef ASSERT_VERDICT_LAT_STATS_EN
  ,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max
`endif
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             verdict_valid_q, verdict_valid_d;
  logic             verdict_q, verdict_d;
  logic [LAT_W-1:0] verdict_lat_q, verdict_lat_d;
  logic             err_pulse_q, err_pulse_d;
  logic [3:0]       err_code_q, err_code_d;
  logic [3:0]       err_set;
  logic             inc_pass, inc_fail, inc_att;
  logic             got_verdict, timed_out, done;

  // A verdict (or timeout) closes the current attempt, which is what allows a same-cycle restart.
  assign got_verdict = (state_q == WAIT) && (match || fail);
  assign timed_out   = (state_q == WAIT) && !(match || fail) && (lat_q == LAT_W'(TIMEOUT));
  assign done        = got_verdict || timed_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      lat_q           <= '0;
      verdict_valid_q <= 1'b0;
      verdict_q       <= 1'b0;
      verdict_lat_q   <= '0;
      err_pulse_q     <= 1'b0;
      err_code_q      <= '0;
    end else begin
      state_q         <= state_d;
      lat_q           <= lat_d;
      verdict_valid_q <= verdict_valid_d;
      verdict_q       <= verdict_d;
      verdict_lat_q   <= verdict_lat_d;
      err_pulse_q     <= err_pulse_d;
      err_code_q      <= err_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      WAIT: begin
        if (done) begin
          if (en) begin
            lat_d = LAT_W'(1);
          end else begin
            state_d = IDLE;
            lat_d   = '0;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  always_comb begin
    verdict_valid_d = done;
    verdict_d       = verdict_q;
    verdict_lat_d   = verdict_lat_q;
    inc_pass        = 1'b0;
    inc_fail        = 1'b0;
    inc_att         = en && ((state_q == IDLE) || done);
    err_set         = '0;
    if (state_q == IDLE) begin
      err_set[ERR_SPURIOUS] = match || fail;
    end else begin
      if (fail) begin
        verdict_d          = 1'b0;
        verdict_lat_d      = lat_q;
        inc_fail           = 1'b1;
        err_set[ERR_BOTH]  = match;
      end else if (match) begin
        verdict_d     = 1'b1;
        verdict_lat_d = lat_q;
        inc_pass      = 1'b1;
      end else if (timed_out) begin
        verdict_d            = 1'b0;
        verdict_lat_d        = LAT_W'(TIMEOUT);
        inc_fail             = 1'b1;
        err_set[ERR_TIMEOUT] = 1'b1;
      end
      err_set[ERR_OVERLAP] = en && !done;
    end
    err_pulse_d = |err_set;
    err_code_d  = clr ? 4'b0 : (err_code_q | err_set);
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_pass), .count(pass_cnt)
  );
  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_fail), .count(fail_cnt)
  );
  sat_counter #(.W(CNT_W)) u_attempt_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc_att), .count(attempt_cnt)
  );

`ifdef ASSERT_VERDICT_LAT_STATS_EN
  logic [LAT_W-1:0] lat_min_q, lat_min_d, lat_max_q, lat_max_d;

  always_comb begin
    lat_min_d = lat_min_q;
    lat_max_d = lat_max_q;
    if (clr) begin
      lat_min_d = '1;
      lat_max_d = '0;
    end else if (inc_pass) begin
      if (lat_q < lat_min_q) lat_min_d = lat_q;
      if (lat_q > lat_max_q) lat_max_d = lat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_min_q <= '1;
      lat_max_q <= '0;
    end else begin
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign lat_min = lat_min_q;
  assign lat_max = lat_max_q;
`endif

  assign pending       = (state_q == WAIT);
  assign verdict_valid = verdict_valid_q;
  assign verdict       = verdict_q;
  assign verdict_lat   = verdict_lat_q;
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_assert_verdict_tracker.sv
// Scoreboard bench for assert_verdict_tracker: timestamp-based reference model, queued expectations.
module tb_assert_verdict_tracker;

  localparam int CNT_W   = 16;
  localparam int LAT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0, match = 1'b0, fail = 1'b0, clr = 1'b0;
  logic             pending, verdict_valid, verdict, err_pulse;
  logic [LAT_W-1:0] verdict_lat;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, attempt_cnt;
  logic [3:0]       err_code;
`ifdef ASSERT_VERDICT_LAT_STATS_EN
  logic [LAT_W-1:0] lat_min, lat_max;
`endif

  assert_verdict_tracker #(.CNT_W(CNT_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .match(match), .fail(fail), .clr(clr),
    .pending(pending), .verdict_valid(verdict_valid), .verdict(verdict),
    .verdict_lat(verdict_lat), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .attempt_cnt(attempt_cnt), .err_pulse(err_pulse), .err_code(err_code)
`ifdef ASSERT_VERDICT_LAT_STATS_EN
    , .lat_min(lat_min), .lat_max(lat_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int lat;
    int p;
    int f;
    int a;
  } vexp_t;

  vexp_t vq[$];
  int    eq[$];

  int checks = 0;
  int errors = 0;

  // reference model state: attempts are tracked by start timestamp
  int cyc = 0;
  bit busy = 0;
  int start_cyc = 0;
  int m_pass = 0, m_fail = 0, m_att = 0, m_code = 0;
  int m_lmin = (1 << LAT_W) - 1, m_lmax = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_edge(input bit e, input bit m, input bit f, input bit c);
    int  err;
    bit  ev;
    int  vv;
    int  lat;
    vexp_t it;
    err = 0; ev = 0; vv = 0; lat = 0;
    if (!busy) begin
      if (m || f) err |= 8;
      if (e) begin
        busy = 1; start_cyc = cyc; m_att = sat(m_att);
      end
    end else begin
      lat = cyc - start_cyc;
      if (m || f) begin
        ev = 1;
        vv = f ? 0 : 1;
        if (f) m_fail = sat(m_fail);
        else begin
          m_pass = sat(m_pass);
          if (lat < m_lmin) m_lmin = lat;
          if (lat > m_lmax) m_lmax = lat;
        end
        if (m && f) err |= 4;
      end else if (lat == TIMEOUT) begin
        ev = 1; vv = 0; m_fail = sat(m_fail); err |= 1;
      end
      if (ev) begin
        if (e) begin start_cyc = cyc; m_att = sat(m_att); end
        else busy = 0;
      end else if (e) err |= 2;
    end
    if (c) begin
      m_pass = 0; m_fail = 0; m_att = 0; m_code = 0;
      m_lmin = (1 << LAT_W) - 1; m_lmax = 0;
    end else m_code |= err;
    if (ev) begin
      it.v = vv; it.lat = lat; it.p = m_pass; it.f = m_fail; it.a = m_att;
      vq.push_back(it);
    end
    if (err != 0) eq.push_back(m_code);
    cyc++;
  endtask

  task automatic step(input bit e, input bit m, input bit f, input bit c);
    en = e; match = m; fail = f; clr = c;
    @(posedge clk);
    model_edge(e, m, f, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    en = 0; match = 0; fail = 0; clr = 0; rst_n = 0;
    @(posedge clk);
    busy = 0; m_pass = 0; m_fail = 0; m_att = 0; m_code = 0;
    m_lmin = (1 << LAT_W) - 1; m_lmax = 0; cyc++;
    #1;
    rst_n = 1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pending"}, int'(pending), int'(busy));
    check({tag, ".pass_cnt"}, int'(pass_cnt), m_pass);
    check({tag, ".fail_cnt"}, int'(fail_cnt), m_fail);
    check({tag, ".attempt_cnt"}, int'(attempt_cnt), m_att);
    check({tag, ".err_code"}, int'(err_code), m_code);
`ifdef ASSERT_VERDICT_LAT_STATS_EN
    check({tag, ".lat_min"}, int'(lat_min), m_lmin);
    check({tag, ".lat_max"}, int'(lat_max), m_lmax);
`endif
  endtask

  // monitor: every pulse must match exactly one queued expectation from the same edge
  always @(negedge clk) begin
    vexp_t x;
    int    ec;
    if (vq.size() > 0) begin
      x = vq.pop_front();
      check("verdict_valid", int'(verdict_valid), 1);
      if (verdict_valid) begin
        check("verdict", int'(verdict), x.v);
        check("verdict_lat", int'(verdict_lat), x.lat);
        check("pass_cnt@verdict", int'(pass_cnt), x.p);
        check("fail_cnt@verdict", int'(fail_cnt), x.f);
        check("attempt_cnt@verdict", int'(attempt_cnt), x.a);
      end
    end else if (verdict_valid) begin
      check("unexpected verdict_valid", 1, 0);
    end
    if (eq.size() > 0) begin
      ec = eq.pop_front();
      check("err_pulse", int'(err_pulse), 1);
      if (err_pulse) check("err_code@pulse", int'(err_code), ec);
    end else if (err_pulse) begin
      check("unexpected err_pulse", 1, 0);
    end
  end

  initial begin
    do_reset();
    do_reset();
    check("reset.verdict_valid", int'(verdict_valid), 0);
    check("reset.verdict_lat", int'(verdict_lat), 0);
    check_state("reset");

    // match after 3 cycles
    step(1, 0, 0, 0); idle(2); step(0, 1, 0, 0);
    check_state("pass3");
    check("pass3.pending_low", int'(pending), 0);

    // fail at latency 6
    step(1, 0, 0, 0); idle(5); step(0, 0, 1, 0);
    check_state("fail6");

    // timeout
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); idle(10);
    check_state("timeout");
    check("timeout.err_code", int'(err_code), 1);

    // overlap, then match+fail together
    step(0, 0, 0, 1);
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0);
    check_state("overlap");
    step(1, 0, 0, 0); step(0, 1, 1, 0);
    check_state("both");

    // spurious, clr, reset mid-attempt
    step(0, 1, 0, 0);
    check_state("spurious");
    step(0, 0, 0, 1);
    check_state("clr");
    step(1, 0, 0, 0); idle(2);
    do_reset();
    check_state("reset_mid");
    idle(2);

    // pass latencies 2,5,3 for min/max tracking; back-to-back restarts inside
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 1, 0, 0);
    idle(4); step(1, 1, 0, 0);
    idle(2); step(0, 1, 0, 0);
    check_state("latstats");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      if (i % 100 == 0) check_state("random");
    end
    idle(TIMEOUT + 2);
    check_state("random_end");

    // pass counter saturation via back-to-back pass stream
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < CMAX + 4; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check_state("saturate");
    check("saturate.pass_cnt", int'(pass_cnt), CMAX);

    idle(3);
    check("vq_drained", vq.size(), 0);
    check("eq_drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
